uart_msg_sequencer: RTL and testbench

UART_MSG_SEQUENCER -- requirements
Module: uart_msg_sequencer

---
 rtl/uart_pkg.sv | 35 +++
 rtl/msg_rom.sv | 44 ++++
 rtl/uart_msg_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_uart_msg_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART message sequencer: FSM/phase encodings,
// ASCII control characters and default parameter values.
package uart_pkg;

  localparam int unsigned DEF_NUM_MSG    = 8;
  localparam int unsigned DEF_MAX_LEN    = 48;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_CRLF_EN    = 1;

  // Each ROM entry is stored as a fixed-width, left-aligned character field.
  localparam int unsigned ROM_CHARS = 8;
  localparam int unsigned ROM_LEN_W = 4;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

  // Which character source the sequencer is currently draining.
  typedef enum logic [2:0] {
    PH_TEXT,
    PH_LF,
    PH_CR,
    PH_ECHO,
    PH_DONE
  } phase_t;

endpackage

// File: rtl/msg_rom.sv
// Fixed message strings with a per-message length table, read
// combinationally by (id, index).
module msg_rom
  import uart_pkg::*;
#(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned IDX_W = 6
) (
  input  logic [ID_W-1:0]      i_id,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [7:0]           o_char_c,
  output logic [ROM_LEN_W-1:0] o_len_c
);

  logic [8*ROM_CHARS-1:0] w_str;
  int unsigned            w_pos;

  // Banner B is padded with NULs past its text; the NUL ends it early.
  always_comb begin
    w_str   = '0;
    o_len_c = '0;
    case (32'(i_id))
      0: begin w_str = {"Hello", 24'h0};  o_len_c = ROM_LEN_W'(5); end
      1: begin w_str = {"Mode?", 24'h0};  o_len_c = ROM_LEN_W'(5); end
      2: begin w_str = {"Mode I", 16'h0}; o_len_c = ROM_LEN_W'(6); end
      3: begin w_str = {"Mode L", 16'h0}; o_len_c = ROM_LEN_W'(6); end
      4: begin w_str = {"Mode A", 16'h0}; o_len_c = ROM_LEN_W'(6); end
      5: begin w_str = {"Mode B", 16'h0}; o_len_c = ROM_LEN_W'(8); end
      default: begin
        w_str   = '0;
        o_len_c = '0;
      end
    endcase
  end

  always_comb begin
    w_pos    = 32'(i_idx);
    o_char_c = ASCII_NUL;
    if (w_pos < ROM_CHARS) begin
      o_char_c = 8'(w_str >> (8 * (ROM_CHARS - 1 - w_pos)));
    end
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams stored messages (plus optional LF/CR) and keyboard-echo bytes to a
// UART transmitter over a READY/SEND/DATA handshake; echo never splits a message.
module uart_msg_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned NUM_MSG    = DEF_NUM_MSG,
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CRLF_EN    = DEF_CRLF_EN
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       msg_valid,
  input  logic [$clog2(NUM_MSG)-1:0] msg_id,
  output logic                       msg_ready,
  input  logic                       echo_valid,
  input  logic [7:0]                 echo_data,
  output logic                       echo_ready,
  input  logic                       tx_rdy,
  output logic                       tx_send,
  output logic [7:0]                 tx_data,
  output logic                       busy,
  output logic                       drop_flag
);

  localparam int unsigned ID_W  = $clog2(NUM_MSG);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  state_t               r_state, w_state_nxt;
  phase_t               r_phase, w_phase_nxt;
  logic [ID_W-1:0]      r_id, w_id_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_text_done, w_text_done_nxt;
  logic [7:0]           r_echo, w_echo_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic                 r_live;
  logic                 r_drop;
  logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;
  logic [7:0]           r_mem [FIFO_DEPTH];

  logic                 w_full, w_empty, w_push, w_pop;
  logic [7:0]           w_rom_char;
  logic [ROM_LEN_W-1:0] w_rom_len;
  int unsigned          w_len;
  logic                 w_text_end, w_have;
  logic [7:0]           w_char;

  msg_rom #(
    .ID_W  (ID_W),
    .IDX_W (IDX_W)
  ) u_msg_rom (
    .i_id     (r_id),
    .i_idx    (r_idx),
    .o_char_c (w_rom_char),
    .o_len_c  (w_rom_len)
  );

  // Echo FIFO: extra pointer bit distinguishes full from empty.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign echo_ready = r_live && !w_full;
  assign w_push     = echo_valid && echo_ready;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= echo_data;
    end
  end

  // Character selection; r_idx already points at the next character after a send.
  always_comb begin
    w_len      = (32'(w_rom_len) > MAX_LEN) ? MAX_LEN : 32'(w_rom_len);
    w_text_end = r_text_done || (32'(r_id) >= NUM_MSG) ||
                 (32'(r_idx) >= w_len) || (w_rom_char == ASCII_NUL);
    w_char     = ASCII_NUL;
    w_have     = 1'b1;
    case (r_phase)
      PH_TEXT: begin
        w_char = w_text_end ? ASCII_LF : w_rom_char;
        w_have = !w_text_end || (CRLF_EN != 0);
      end
      PH_LF:   w_char = ASCII_LF;
      PH_CR:   w_char = ASCII_CR;
      PH_ECHO: w_char = r_echo;
      default: w_have = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_id_nxt        = r_id;
    w_idx_nxt       = r_idx;
    w_text_done_nxt = r_text_done;
    w_echo_nxt      = r_echo;
    w_tx_data_nxt   = r_tx_data;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (msg_valid && msg_ready) begin
          w_id_nxt        = msg_id;
          w_idx_nxt       = '0;
          w_text_done_nxt = 1'b0;
          w_phase_nxt     = PH_TEXT;
          w_state_nxt     = ST_FETCH;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_echo_nxt  = r_mem[r_rd_ptr[PTR_W-1:0]];
          w_phase_nxt = PH_ECHO;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!w_have) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tx_data_nxt = w_char;
          if (r_phase == PH_TEXT && w_text_end) begin
            w_phase_nxt = PH_LF;
          end
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_rdy) begin
          w_state_nxt = ST_WAIT_LO;
          case (r_phase)
            PH_TEXT: begin
              // Saturate at the last legal index instead of wrapping past it.
              if (32'(r_idx) == MAX_LEN - 1) begin
                w_text_done_nxt = 1'b1;
              end else begin
                w_idx_nxt = r_idx + IDX_ONE;
              end
            end
            PH_LF:   w_phase_nxt = PH_CR;
            default: w_phase_nxt = PH_DONE;
          endcase
        end
      end
      ST_WAIT_LO: begin
        if (!tx_rdy) begin
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_rdy) begin
          w_state_nxt = w_have ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_DONE;
      r_id        <= '0;
      r_idx       <= '0;
      r_text_done <= 1'b0;
      r_echo      <= '0;
      r_tx_data   <= '0;
      r_live      <= 1'b0;
      r_drop      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_id        <= w_id_nxt;
      r_idx       <= w_idx_nxt;
      r_text_done <= w_text_done_nxt;
      r_echo      <= w_echo_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_live      <= 1'b1;
      if (echo_valid && r_live && w_full) begin
        r_drop <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  assign msg_ready = r_live && (r_state == ST_IDLE);
  assign tx_send   = (r_state == ST_SEND) && tx_rdy;
  assign tx_data   = r_tx_data;
  assign busy      = (r_state != ST_IDLE);
  assign drop_flag = r_drop;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer: expected bytes are queued when
// stimulus is issued and checked by a monitor on every tx_send pulse.
module tb_uart_msg_sequencer;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       msg_valid = 1'b0;
  logic [2:0] msg_id = '0;
  logic       echo_valid = 1'b0;
  logic [7:0] echo_data = '0;
  logic       hold = 1'b0;
  logic       tx_rdy;
  logic       msg_ready, echo_ready, tx_send, busy, drop_flag;
  logic [7:0] tx_data;

  int         lo_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];

  uart_msg_sequencer dut (
    .CLK        (CLK),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_id     (msg_id),
    .msg_ready  (msg_ready),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .tx_rdy     (tx_rdy),
    .tx_send    (tx_send),
    .tx_data    (tx_data),
    .busy       (busy),
    .drop_flag  (drop_flag)
  );

  always #5 CLK = ~CLK;

  // UART transmitter model: busy (READY low) for 10 cycles after each send.
  assign tx_rdy = !hold && (lo_cnt == 0);
  always @(posedge CLK or posedge rst) begin
    if (rst) lo_cnt <= 0;
    else if (tx_send && tx_rdy) lo_cnt <= 10;
    else if (lo_cnt > 0) lo_cnt <= lo_cnt - 1;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (!rst && tx_send) begin
      check("tx_rdy_at_send", 32'(tx_rdy), 32'd1);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_send: got %02h, expected no send", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic push_str(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    if (crlf) begin
      sb.push_back(8'h0A);
      sb.push_back(8'h0D);
    end
  endtask

  task automatic req(input logic [2:0] id);
    int k;
    @(negedge CLK);
    msg_valid = 1'b1;
    msg_id    = id;
    for (k = 0; k < 500 && !msg_ready; k++) @(negedge CLK);
    if (!msg_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept: msg_ready stayed %0b, expected 1", msg_ready);
    end
    @(negedge CLK);
    msg_valid = 1'b0;
  endtask

  task automatic echo_wr(input logic [7:0] d);
    @(negedge CLK);
    echo_valid = 1'b1;
    echo_data  = d;
    @(negedge CLK);
    echo_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge CLK);
      if (!busy && sb.size() == 0) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: timeout with busy=%0b pending=%0d, expected idle with 0 pending",
               name, busy, sb.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_flag), 32'd0);
    check("rst_msg_ready", 32'(msg_ready), 32'd0);
    check("rst_echo_ready", 32'(echo_ready), 32'd0);
    rst = 1'b0;
    @(negedge CLK);
    check("post_rst_msg_ready", 32'(msg_ready), 32'd1);
    check("post_rst_echo_ready", 32'(echo_ready), 32'd1);

    // "Hello" with CRLF, plus request-to-send latency
    push_str("Hello", 1);
    msg_valid = 1'b1;
    msg_id    = 3'd0;
    @(negedge CLK);
    msg_valid = 1'b0;
    check("lat_fetch_no_send", 32'(tx_send), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("lat_send", 32'(tx_send), 32'd1);
    wait_idle("hello_done");
    check("hello_msg_ready", 32'(msg_ready), 32'd1);

    // Echo bytes written mid-message follow its terminator
    push_str("Mode?", 1);
    sb.push_back(8'h61);
    sb.push_back(8'h0A);
    req(3'd1);
    repeat (5) @(negedge CLK);
    echo_wr(8'h61);
    echo_wr(8'h0A);
    wait_idle("echo_after_msg");

    // Same-cycle message request and echo write
    push_str("Mode I", 1);
    sb.push_back(8'h7A);
    @(negedge CLK);
    msg_valid  = 1'b1;
    msg_id     = 3'd2;
    echo_valid = 1'b1;
    echo_data  = 8'h7A;
    @(negedge CLK);
    msg_valid  = 1'b0;
    echo_valid = 1'b0;
    wait_idle("msg_wins");

    // Empty ROM slot: only LF/CR
    push_str("", 1);
    req(3'd7);
    wait_idle("empty_msg");
    check("empty_msg_ready", 32'(msg_ready), 32'd1);

    // Embedded NUL ends the message before its table length
    push_str("Mode B", 1);
    req(3'd5);
    wait_idle("nul_term");

    // FIFO overflow while the transmitter is stalled
    hold = 1'b1;
    push_str("Hello", 1);
    req(3'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      if (i == 7) check("ovf_drop_before", 32'(drop_flag), 32'd0);
      if (i == 8) check("ovf_echo_ready_full", 32'(echo_ready), 32'd0);
      echo_valid = 1'b1;
      echo_data  = 8'(8'h30 + i);
      if (i < 8) sb.push_back(8'(8'h30 + i));
    end
    @(negedge CLK);
    echo_valid = 1'b0;
    check("ovf_drop_set", 32'(drop_flag), 32'd1);
    hold = 1'b0;
    wait_idle("ovf_drain");
    check("ovf_drop_sticky", 32'(drop_flag), 32'd1);
    check("ovf_echo_ready_after", 32'(echo_ready), 32'd1);

    // Reset after the third character aborts the message
    push_str("Mod", 0);
    req(3'd3);
    done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge CLK);
      if (sb.size() == 0) done = 1;
    end
    check("abort_three_sent", 32'(sb.size()), 32'd0);
    @(posedge CLK);
    #1 rst = 1'b1;
    #1;
    check("abort_tx_send", 32'(tx_send), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_drop_cleared", 32'(drop_flag), 32'd0);
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    repeat (60) @(negedge CLK);
    check("abort_no_resume", 32'(busy), 32'd0);
    check("abort_msg_ready", 32'(msg_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
